// File: rtl/swa_pkg.sv
// swa_pkg: shared FSM state type, default width and counter sizing helper
// for the serial word assembler.
package swa_pkg;

    localparam int SWA_DEFAULT_WIDTH = 8;

    // IDLE: no bits held; COLLECT: partial word; LAST: one bit short of a word.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        LAST    = 2'd2
    } swa_state_e;

    // Width of a counter able to hold every value 0..width inclusive.
    function automatic int swa_count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/swa_out_reg.sv
// swa_out_reg: output holding register with valid/ready handshake for the
// serial word assembler. A completed word loads here and stays put until the
// consumer takes it.
// Optional feature: define SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN to add a 16-bit
// wrapping count of transferred words.
module swa_out_reg import swa_pkg::*; #(
    parameter int DATA_WIDTH = SWA_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid
`ifdef SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN
    ,
    output logic [15:0]           word_count
`endif
);

    logic transfer;

    assign transfer = word_valid && word_ready;

    // Load on completion (keeps valid high even if the old word leaves in the
    // same cycle), otherwise drop valid once the held word is taken.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (load) begin
            word_out   <= load_data;
            word_valid <= 1'b1;
        end else if (transfer) begin
            word_valid <= 1'b0;
        end
    end

`ifdef SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN
    // Count transferred words; the 16-bit add wraps 0xFFFF -> 0x0000 on its own.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count <= '0;
        end else if (transfer) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/serial_word_assembler.sv
// serial_word_assembler: gathers serial bits into DATA_WIDTH-bit words and
// hands them to a downstream stage through a valid/ready holding register.
// MSB_FIRST selects whether the first received bit lands in the top or the
// bottom bit of the word. frame_start drops any partial word.
// Optional feature: define SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN to add the
// word_count output (16-bit wrapping count of transferred words).
module serial_word_assembler import swa_pkg::*; #(
    parameter int DATA_WIDTH = SWA_DEFAULT_WIDTH,
    parameter int MSB_FIRST  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic                              bit_in,
    input  logic                              bit_valid,
    output logic                              bit_ready,
    output logic [DATA_WIDTH-1:0]             word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   bit_count
`ifdef SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN
    ,
    output logic [15:0]                       word_count
`endif
);

    localparam int            CW         = swa_count_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    swa_state_e            state_q;
    swa_state_e            state_d;
    swa_state_e            base_state;
    logic [CW-1:0]         base_count;
    logic [CW-1:0]         count_d;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] base_shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic                  accept;
    logic                  complete;

    // Only the final bit of a word can be refused, and only while the previous
    // word is still waiting; a frame restart never completes, so it is never held off.
    assign bit_ready = frame_start || !((state_q == LAST) && word_valid && !word_ready);
    assign accept    = bit_valid && bit_ready;

    // Next state, bit count and shift contents; frame_start rewinds to an
    // empty word before the accepted bit (if any) is applied.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        base_state = state_q;
        base_count = bit_count;
        base_shreg = shreg;
        if (frame_start) begin
            base_state = IDLE;
            base_count = '0;
            base_shreg = '0;
        end

        if (MSB_FIRST != 0) begin
            shifted = {base_shreg[DATA_WIDTH-2:0], bit_in};
        end else begin
            shifted = {bit_in, base_shreg[DATA_WIDTH-1:1]};
        end

        state_d  = base_state;
        count_d  = base_count;
        shreg_d  = base_shreg;
        complete = 1'b0;

        if (accept) begin
            shreg_d = shifted;
            if (base_state == LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                count_d  = '0;
            end else begin
                count_d = base_count + CW'(1);
                state_d = (count_d == LAST_COUNT) ? LAST : COLLECT;
            end
        end
    end

    // State register, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_count <= '0;
            shreg     <= '0;
        end else begin
            state_q   <= state_d;
            bit_count <= count_d;
            shreg     <= shreg_d;
        end
    end

    swa_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (shifted),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid)
`ifdef SERIAL_WORD_ASSEMBLER_WORD_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

endmodule
